// File: rtl/subway_path_checker.sv
// subway_path_checker: downstream scoreboard stage for the SUBWAY path-finder.
// It captures the 4-lane x COLS-column map and the start lane, replays the
// COLS-1 move stream cell by cell, and pulses a one-cycle result that reports
// the first offending step.
// Optional feature: define SUBWAY_CHK_STRICT_JUMP_EN to make a jump legal only
// onto a low obstacle (cell code 1). Without it, a jump is legal onto any cell
// except a train.
module subway_path_checker #(
  parameter int COLS = 64,
  parameter int CW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    init,
  input  logic [1:0]    in0,
  input  logic [1:0]    in1,
  input  logic [1:0]    in2,
  input  logic [1:0]    in3,
  input  logic          mv_valid,
  input  logic [1:0]    mv,
  output logic          res_valid,
  output logic          res_pass,
  output logic [CW-1:0] err_step,
  output logic [1:0]    err_code,
  output logic [1:0]    final_lane
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    REPORT
  } state_t;

  // Cell codes
  localparam logic [1:0] CELL_ROAD  = 2'd0;
  localparam logic [1:0] CELL_LOW   = 2'd1;
  localparam logic [1:0] CELL_HIGH  = 2'd2;
  localparam logic [1:0] CELL_TRAIN = 2'd3;

  // Move codes
  localparam logic [1:0] MV_FWD   = 2'd0;
  localparam logic [1:0] MV_RIGHT = 2'd1;
  localparam logic [1:0] MV_LEFT  = 2'd2;
  localparam logic [1:0] MV_JUMP  = 2'd3;

  // Error codes
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_FWD  = 2'd1;
  localparam logic [1:0] ERR_LANE = 2'd2;
  localparam logic [1:0] ERR_JUMP = 2'd3;

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(COLS - 2);

  state_t state;
  state_t state_next;

  // Map contents are never reset; every run overwrites all columns
  logic [1:0] map_mem [0:3][0:COLS-1];

  logic [CW-1:0] load_cnt;
  logic [CW-1:0] wr_col;
  logic [1:0]    init_lane;

  logic [CW-1:0] step;
  logic [CW-1:0] chk_col;
  logic [1:0]    lane;
  logic          err_seen;
  logic [CW-1:0] err_step_r;
  logic [1:0]    err_code_r;

  logic          load_done;
  logic          restart;
  logic          mv_fire;
  logic          last_move;

  logic [1:0]    cell_here;
  logic [1:0]    cell_left;
  logic [1:0]    cell_right;
  logic          mv_ok;
  logic [1:0]    mv_code;
  logic [1:0]    lane_after;

  logic          fin_pass;
  logic [CW-1:0] fin_step;
  logic [1:0]    fin_code;
  logic [1:0]    fin_lane;

  // Event decode: a fresh in_valid outside LOAD always restarts a run, and
  // it wins over a coincident move so an aborted run never reports
  always_comb begin
    load_done = (state == LOAD) && in_valid && (load_cnt == LAST_COL);
    restart   = in_valid && (state != LOAD);
    mv_fire   = (state == PLAY) && mv_valid && !in_valid;
    last_move = mv_fire && (step == LAST_STEP);
    wr_col    = (state == LOAD) ? load_cnt : '0;
    chk_col   = step + CW'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        if (load_done) state_next = PLAY;
      end
      PLAY: begin
        if (in_valid)       state_next = LOAD;
        else if (last_move) state_next = REPORT;
      end
      REPORT: begin
        if (in_valid) state_next = LOAD;
        else          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Map capture: one column per in_valid beat, column 0 on any restart
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      map_mem[0][wr_col] <= in0;
      map_mem[1][wr_col] <= in1;
      map_mem[2][wr_col] <= in2;
      map_mem[3][wr_col] <= in3;
    end
  end

  // Legality of the current move against column step+1; lane indices that
  // would wrap are read but never used because the edge lane check wins
  always_comb begin
    cell_here  = map_mem[lane][chk_col];
    cell_left  = map_mem[lane - 2'd1][chk_col];
    cell_right = map_mem[lane + 2'd1][chk_col];
    mv_ok      = 1'b1;
    mv_code    = ERR_NONE;
    lane_after = lane;
    case (mv)
      MV_FWD: begin
        if (cell_here != CELL_ROAD && cell_here != CELL_HIGH) begin
          mv_ok   = 1'b0;
          mv_code = ERR_FWD;
        end
      end
      MV_RIGHT: begin
        if (lane == 2'd3 || cell_right != CELL_ROAD) begin
          mv_ok   = 1'b0;
          mv_code = ERR_LANE;
        end else begin
          lane_after = lane + 2'd1;
        end
      end
      MV_LEFT: begin
        if (lane == 2'd0 || cell_left != CELL_ROAD) begin
          mv_ok   = 1'b0;
          mv_code = ERR_LANE;
        end else begin
          lane_after = lane - 2'd1;
        end
      end
      MV_JUMP: begin
`ifdef SUBWAY_CHK_STRICT_JUMP_EN
        if (cell_here != CELL_LOW) begin
          mv_ok   = 1'b0;
          mv_code = ERR_JUMP;
        end
`else
        if (cell_here == CELL_TRAIN) begin
          mv_ok   = 1'b0;
          mv_code = ERR_JUMP;
        end
`endif
      end
      default: begin
        mv_ok   = 1'b1;
        mv_code = ERR_NONE;
      end
    endcase
  end

  // Load counter and start lane; the start lane is only taken on column 0
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      init_lane <= 2'd0;
    end else if (restart) begin
      load_cnt  <= CW'(1);
      init_lane <= init;
    end else if (state == LOAD && in_valid) begin
      load_cnt  <= load_cnt + CW'(1);
    end
  end

  // Replay state: lane and step advance on legal moves; the first failure
  // freezes the lane and is latched while later moves are only counted
  always_ff @(posedge clk) begin
    if (rst) begin
      step       <= '0;
      lane       <= 2'd0;
      err_seen   <= 1'b0;
      err_step_r <= '0;
      err_code_r <= ERR_NONE;
    end else if (load_done) begin
      step       <= '0;
      lane       <= init_lane;
      err_seen   <= 1'b0;
      err_step_r <= '0;
      err_code_r <= ERR_NONE;
    end else if (mv_fire) begin
      step <= step + CW'(1);
      if (!err_seen) begin
        if (mv_ok) begin
          lane <= lane_after;
        end else begin
          err_seen   <= 1'b1;
          err_step_r <= step;
          err_code_r <= mv_code;
        end
      end
    end
  end

  // Final verdict including the effect of the move being consumed now
  always_comb begin
    fin_pass = 1'b1;
    fin_step = '0;
    fin_code = ERR_NONE;
    fin_lane = lane_after;
    if (err_seen) begin
      fin_pass = 1'b0;
      fin_step = err_step_r;
      fin_code = err_code_r;
      fin_lane = lane;
    end else if (!mv_ok) begin
      fin_pass = 1'b0;
      fin_step = step;
      fin_code = mv_code;
      fin_lane = lane;
    end
  end

  // Registered result: pulse on the REPORT cycle, fields held until the next
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      err_step   <= '0;
      err_code   <= ERR_NONE;
      final_lane <= 2'd0;
    end else begin
      res_valid <= last_move;
      if (last_move) begin
        res_pass   <= fin_pass;
        err_step   <= fin_step;
        err_code   <= fin_code;
        final_lane <= fin_lane;
      end
    end
  end

endmodule

// File: tb/tb_subway_path_checker.sv
// tb_subway_path_checker: directed bench for subway_path_checker (COLS = 64).
// Expected values are hand-computed from each directed map and move list.
module tb_subway_path_checker;

  localparam int COLS = 64;
  localparam int CW   = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [1:0]    init;
  logic [1:0]    in0;
  logic [1:0]    in1;
  logic [1:0]    in2;
  logic [1:0]    in3;
  logic          mv_valid;
  logic [1:0]    mv;
  logic          res_valid;
  logic          res_pass;
  logic [CW-1:0] err_step;
  logic [1:0]    err_code;
  logic [1:0]    final_lane;

  int errors = 0;
  int checks = 0;
  int res_count = 0;
  int cnt_before;

  logic [1:0] tb_map   [0:3][0:COLS-1];
  logic [1:0] tb_moves [0:COLS-2];

  subway_path_checker #(.COLS(COLS), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .init       (init),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .mv_valid   (mv_valid),
    .mv         (mv),
    .res_valid  (res_valid),
    .res_pass   (res_pass),
    .err_step   (err_step),
    .err_code   (err_code),
    .final_lane (final_lane)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every result pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (res_valid === 1'b1) res_count <= res_count + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_map();
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < COLS; c++)
        tb_map[l][c] = 2'd0;
  endtask

  task automatic clear_moves();
    for (int i = 0; i < COLS - 1; i++) tb_moves[i] = 2'd0;
  endtask

  // Drive the whole map; init is scrambled after column 0 and a right move
  // is offered throughout LOAD to show that both are ignored there
  task automatic send_map(input logic [1:0] start, input bit gaps);
    for (int c = 0; c < COLS; c++) begin
      if (gaps && (c % 7 == 3)) begin
        in_valid = 1'b0;
        mv_valid = 1'b1;
        mv       = 2'd1;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      init     = (c == 0) ? start : ~start;
      in0      = tb_map[0][c];
      in1      = tb_map[1][c];
      in2      = tb_map[2][c];
      in3      = tb_map[3][c];
      mv_valid = (c != 0);
      mv       = 2'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mv_valid = 1'b0;
    mv       = 2'd0;
  endtask

  task automatic send_moves(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && (i % 5 == 2)) begin
        mv_valid = 1'b0;
        @(posedge clk); #1;
      end
      mv_valid = 1'b1;
      mv       = tb_moves[i];
      @(posedge clk); #1;
    end
    mv_valid = 1'b0;
    mv       = 2'd0;
  endtask

  // Called #1 after the last move edge: the result must be up right now,
  // gone one cycle later with its fields held, and pulsed exactly once
  task automatic check_result(input string tag, input logic p, input logic [CW-1:0] s,
                              input logic [1:0] code, input logic [1:0] ln, input int base);
    check_output({tag, ".res_valid"},  res_valid,  1);
    check_output({tag, ".res_pass"},   res_pass,   p);
    check_output({tag, ".err_step"},   err_step,   s);
    check_output({tag, ".err_code"},   err_code,   code);
    check_output({tag, ".final_lane"}, final_lane, ln);
    @(posedge clk); #1;
    check_output({tag, ".pulse_end"},  res_valid,  0);
    check_output({tag, ".hold_pass"},  res_pass,   p);
    check_output({tag, ".pulses"},     res_count - base, 1);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; in_valid = 1'b0; init = 2'd0; mv_valid = 1'b0; mv = 2'd0;
    in0 = 2'd0; in1 = 2'd0; in2 = 2'd0; in3 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.res_valid",  res_valid,  0);
    check_output("reset.res_pass",   res_pass,   0);
    check_output("reset.err_step",   err_step,   0);
    check_output("reset.err_code",   err_code,   0);
    check_output("reset.final_lane", final_lane, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] all-road, init 1, all forward");
    clear_map(); clear_moves();
    cnt_before = res_count;
    send_map(2'd1, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("road", 1, 0, 0, 1, cnt_before);

    $display("[TB] train lane 0 col 10, right at step 9, with gaps");
    clear_map(); clear_moves();
    tb_map[0][10] = 2'd3;
    tb_moves[9] = 2'd1;
    cnt_before = res_count;
    send_map(2'd0, 1'b1);
    send_moves(0, COLS - 2, 1'b1);
    check_result("dodge", 1, 0, 0, 1, cnt_before);

    $display("[TB] same map, forward into train");
    clear_moves();
    cnt_before = res_count;
    send_map(2'd0, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("crash", 0, 9, 1, 0, cnt_before);

    $display("[TB] init 3, right at step 0, later train ignored");
    clear_map(); clear_moves();
    tb_map[3][30] = 2'd3;
    tb_moves[0] = 2'd1;
    cnt_before = res_count;
    send_map(2'd3, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("right_edge", 0, 0, 2, 3, cnt_before);

    $display("[TB] left from lane 0");
    clear_map(); clear_moves();
    tb_moves[5] = 2'd2;
    cnt_before = res_count;
    send_map(2'd0, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("left_edge", 0, 5, 2, 0, cnt_before);

    $display("[TB] left onto high obstacle");
    clear_map(); clear_moves();
    tb_map[0][12] = 2'd2;
    tb_moves[11] = 2'd2;
    cnt_before = res_count;
    send_map(2'd1, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("left_high", 0, 11, 2, 1, cnt_before);

    $display("[TB] jump low obstacle, pass under high, legal left");
    clear_map(); clear_moves();
    tb_map[2][5] = 2'd1;
    tb_map[2][8] = 2'd2;
    tb_moves[4]  = 2'd3;
    tb_moves[20] = 2'd2;
    cnt_before = res_count;
    send_map(2'd2, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("jump_low", 1, 0, 0, 1, cnt_before);

    $display("[TB] forward onto low obstacle");
    clear_moves();
    cnt_before = res_count;
    send_map(2'd2, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("fwd_low", 0, 4, 1, 2, cnt_before);

    $display("[TB] jump onto road at step 19");
    clear_map(); clear_moves();
    tb_moves[19] = 2'd3;
    cnt_before = res_count;
    send_map(2'd0, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
`ifdef SUBWAY_CHK_STRICT_JUMP_EN
    check_result("jump_road", 0, 19, 3, 0, cnt_before);
`else
    check_result("jump_road", 1, 0, 0, 0, cnt_before);
`endif

    $display("[TB] jump onto train");
    clear_map(); clear_moves();
    tb_map[1][40] = 2'd3;
    tb_moves[39] = 2'd3;
    cnt_before = res_count;
    send_map(2'd1, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("jump_train", 0, 39, 3, 1, cnt_before);

    $display("[TB] abort at move 30, then full run");
    clear_map(); clear_moves();
    cnt_before = res_count;
    send_map(2'd0, 1'b0);
    send_moves(0, 29, 1'b0);
    clear_map();
    tb_map[3][2] = 2'd3;
    tb_moves[0] = 2'd1;
    send_map(2'd2, 1'b0);
    check_output("abort.no_pulse", res_count - cnt_before, 0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("after_abort", 0, 1, 1, 3, cnt_before);

    $display("[TB] reset during PLAY");
    clear_map(); clear_moves();
    tb_moves[3] = 2'd1;
    send_map(2'd1, 1'b0);
    send_moves(0, 10, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("rst_play.res_valid",  res_valid,  0);
    check_output("rst_play.res_pass",   res_pass,   0);
    check_output("rst_play.err_step",   err_step,   0);
    check_output("rst_play.err_code",   err_code,   0);
    check_output("rst_play.final_lane", final_lane, 0);
    cnt_before = res_count;
    send_moves(0, COLS - 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_play.idle_moves", res_count - cnt_before, 0);

    $display("[TB] recovery run after reset");
    clear_map(); clear_moves();
    tb_moves[0]  = 2'd1;
    tb_moves[1]  = 2'd1;
    cnt_before = res_count;
    send_map(2'd1, 1'b0);
    send_moves(0, COLS - 2, 1'b0);
    check_result("recover", 1, 0, 0, 3, cnt_before);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
